// File: rtl/shot_clock_controller.sv
// Shot-clock sequencer: reloads, runs, pauses, expires and blanks the 24/14 s
// shot-clock counter, with an internal 1 s prescaler and a fixed-length horn.
module shot_clock_controller #(
    parameter int CLK_DIV     = 50_000_000,
    parameter int BUZZ_CYCLES = 25_000_000,
    parameter int FULL_VAL    = 24,
    parameter int SHORT_VAL   = 14
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        reload24,
    input  logic        reload14,
    input  logic [11:0] game_secs,
    input  logic        game_valid,
    output logic [4:0]  seconds,
    output logic        running,
    output logic        expired,
    output logic        blank,
    output logic        buzzer
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BUZZ_LOAD = BW'(BUZZ_CYCLES - 1);
    localparam logic [4:0]    FULL_SEC  = 5'(FULL_VAL);
    localparam logic [4:0]    SHORT_SEC = 5'(SHORT_VAL);

    localparam logic [1:0] ST_PAUSE   = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;
    localparam logic [1:0] ST_OFF     = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [4:0]    seconds_nxt;
    logic [PW-1:0] prescaler, prescaler_nxt;
    logic [BW-1:0] buzz_cnt;
    logic          buzz_fire;
    logic          leaving_idle;
    logic          off_hit;

    assign leaving_idle = (state == ST_EXPIRED) || (state == ST_OFF);
    assign off_hit      = ((state == ST_PAUSE) || (state == ST_RUN)) && game_valid
                          && (game_secs < {7'd0, seconds});

    // Only the highest-priority command acts; the OFF check and the countdown
    // run only in cycles where no command is asserted.
    always_comb begin
        state_nxt     = state;
        seconds_nxt   = seconds;
        prescaler_nxt = prescaler;
        buzz_fire     = 1'b0;
        if (reload24) begin
            seconds_nxt   = FULL_SEC;
            prescaler_nxt = '0;
            if (leaving_idle) state_nxt = ST_PAUSE;
        end else if (reload14) begin
            if ((seconds < SHORT_SEC) || leaving_idle) begin
                seconds_nxt   = SHORT_SEC;
                prescaler_nxt = '0;
            end
            if (leaving_idle) state_nxt = ST_PAUSE;
        end else if (stop) begin
            if (state == ST_RUN) state_nxt = ST_PAUSE;
        end else if (start) begin
            if (state == ST_PAUSE) state_nxt = ST_RUN;
        end else if (off_hit) begin
            state_nxt = ST_OFF;
        end else if (state == ST_RUN) begin
            if (prescaler == PRE_LAST) begin
                prescaler_nxt = '0;
                if (seconds <= 5'd1) begin
                    seconds_nxt = 5'd0;
                    state_nxt   = ST_EXPIRED;
                    buzz_fire   = 1'b1;
                end else begin
                    seconds_nxt = seconds - 5'd1;
                end
            end else begin
                prescaler_nxt = prescaler + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_PAUSE;
            seconds   <= FULL_SEC;
            prescaler <= '0;
            running   <= 1'b0;
            expired   <= 1'b0;
            blank     <= 1'b0;
        end else begin
            state     <= state_nxt;
            seconds   <= seconds_nxt;
            prescaler <= prescaler_nxt;
            running   <= (state_nxt == ST_RUN);
            expired   <= (state_nxt == ST_EXPIRED);
            blank     <= (state_nxt == ST_OFF);
        end
    end

    // Horn runs for a fixed number of cycles once fired, independent of reloads.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            buzzer   <= 1'b0;
            buzz_cnt <= '0;
        end else if (buzz_fire) begin
            buzzer   <= 1'b1;
            buzz_cnt <= BUZZ_LOAD;
        end else if (buzz_cnt != '0) begin
            buzz_cnt <= buzz_cnt - 1'b1;
        end else begin
            buzzer <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shot_clock_controller.sv
// Self-checking bench for shot_clock_controller: table-driven vectors plus
// hand-written sequences, all compared through an expected-output queue.
module tb_shot_clock_controller;

    logic        clk;
    logic        reset_n;
    logic        start, stop, reload24, reload14;
    logic [11:0] game_secs;
    logic        game_valid;
    logic [4:0]  seconds;
    logic        running, expired, blank, buzzer;

    typedef struct packed {
        logic [4:0] sec;
        logic       run;
        logic       exp;
        logic       blk;
        logic       buz;
    } out_t;

    typedef struct {
        logic start;
        logic stop;
        logic r24;
        logic r14;
        out_t want;
    } vec_t;

    out_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    shot_clock_controller #(
        .CLK_DIV(4), .BUZZ_CYCLES(3), .FULL_VAL(24), .SHORT_VAL(14)
    ) dut (
        .clock_in(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .reload24(reload24), .reload14(reload14), .game_secs(game_secs),
        .game_valid(game_valid), .seconds(seconds), .running(running),
        .expired(expired), .blank(blank), .buzzer(buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input int sec, input logic run, input logic exp,
                                input logic blk, input logic buz);
        out_t o;
        o.sec = 5'(sec);
        o.run = run;
        o.exp = exp;
        o.blk = blk;
        o.buz = buz;
        return o;
    endfunction

    task automatic checkOutput(input string name);
        out_t want, got;
        got = {seconds, running, expired, blank, buzzer};
        tests++;
        if (sb.size() == 0) begin
            failed++;
            $display("[TB] FAIL %s: no expected value queued", name);
        end else begin
            want = sb.pop_front();
            if (got !== want) begin
                failed++;
                $display("[TB] FAIL %s: got sec=%0d run=%b exp=%b blk=%b buz=%b, want sec=%0d run=%b exp=%b blk=%b buz=%b",
                         name, got.sec, got.run, got.exp, got.blk, got.buz,
                         want.sec, want.run, want.exp, want.blk, want.buz);
            end
        end
    endtask

    // Drives one cycle of commands at the falling edge, then checks after the next rising edge.
    task automatic applyStimulus(input logic s, input logic st, input logic r24,
                                 input logic r14, input out_t want, input string name);
        start    = s;
        stop     = st;
        reload24 = r24;
        reload14 = r14;
        sb.push_back(want);
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        stop     = 1'b0;
        reload24 = 1'b0;
        reload14 = 1'b0;
        checkOutput(name);
    endtask

    vec_t vecs[20];

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        reload24   = 1'b0;
        reload14   = 1'b0;
        game_secs  = 12'd0;
        game_valid = 1'b0;

        // Pause/resume, stop on a tick cycle, ineffective reload14, reload24 in RUN.
        vecs[0]  = '{1, 0, 0, 0, mk(24, 1, 0, 0, 0)};
        vecs[1]  = '{0, 0, 0, 0, mk(24, 1, 0, 0, 0)};
        vecs[2]  = '{0, 0, 0, 0, mk(24, 1, 0, 0, 0)};
        vecs[3]  = '{0, 0, 0, 0, mk(24, 1, 0, 0, 0)};
        vecs[4]  = '{0, 0, 0, 0, mk(23, 1, 0, 0, 0)};
        vecs[5]  = '{0, 0, 0, 0, mk(23, 1, 0, 0, 0)};
        vecs[6]  = '{0, 0, 0, 0, mk(23, 1, 0, 0, 0)};
        vecs[7]  = '{0, 1, 0, 0, mk(23, 0, 0, 0, 0)};
        vecs[8]  = '{0, 0, 0, 0, mk(23, 0, 0, 0, 0)};
        vecs[9]  = '{1, 0, 0, 0, mk(23, 1, 0, 0, 0)};
        vecs[10] = '{0, 0, 0, 0, mk(23, 1, 0, 0, 0)};
        vecs[11] = '{0, 0, 0, 0, mk(22, 1, 0, 0, 0)};
        vecs[12] = '{0, 0, 0, 0, mk(22, 1, 0, 0, 0)};
        vecs[13] = '{0, 0, 0, 0, mk(22, 1, 0, 0, 0)};
        vecs[14] = '{0, 0, 0, 0, mk(22, 1, 0, 0, 0)};
        vecs[15] = '{0, 1, 0, 0, mk(22, 0, 0, 0, 0)};
        vecs[16] = '{1, 0, 0, 0, mk(22, 1, 0, 0, 0)};
        vecs[17] = '{0, 0, 0, 0, mk(21, 1, 0, 0, 0)};
        vecs[18] = '{0, 0, 0, 1, mk(21, 1, 0, 0, 0)};
        vecs[19] = '{0, 0, 1, 0, mk(24, 1, 0, 0, 0)};

        #12;
        sb.push_back(mk(24, 0, 0, 0, 0));
        checkOutput("reset_values");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++)
            applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].r24, vecs[i].r14,
                          vecs[i].want, $sformatf("vec%0d", i));

        // Count down from 24 to 5, then all three high-priority commands at once.
        for (int i = 1; i <= 76; i++)
            applyStimulus(0, 0, 0, 0, mk(24 - i / 4, 1, 0, 0, 0), $sformatf("down_to5_%0d", i));
        applyStimulus(0, 1, 1, 1, mk(24, 1, 0, 0, 0), "priority_r24");

        // Full 96-cycle run to expiry, horn length, reload14 out of EXPIRED mid-buzz.
        for (int i = 1; i <= 96; i++)
            applyStimulus(0, 0, 0, 0, mk(24 - i / 4, i < 96, i == 96, 0, i == 96),
                          $sformatf("expire_%0d", i));
        applyStimulus(0, 0, 0, 1, mk(14, 0, 0, 0, 1), "r14_expired");
        applyStimulus(0, 0, 0, 0, mk(14, 0, 0, 0, 1), "buzz_hold");
        applyStimulus(0, 0, 0, 0, mk(14, 0, 0, 0, 0), "buzz_end");

        // reload14 below SHORT_VAL clears a partial prescaler count.
        applyStimulus(1, 0, 0, 0, mk(14, 1, 0, 0, 0), "start14");
        for (int i = 1; i <= 22; i++)
            applyStimulus(0, 0, 0, 0, mk(14 - i / 4, 1, 0, 0, 0), $sformatf("down_to9_%0d", i));
        applyStimulus(0, 0, 0, 1, mk(14, 1, 0, 0, 0), "r14_at9");
        for (int i = 1; i <= 4; i++)
            applyStimulus(0, 0, 0, 0, mk(14 - i / 4, 1, 0, 0, 0), $sformatf("pre_cleared_%0d", i));

        // OFF entry from PAUSE, start ignored, reload24 exits.
        applyStimulus(0, 0, 1, 0, mk(24, 1, 0, 0, 0), "r24_run");
        applyStimulus(0, 1, 0, 0, mk(24, 0, 0, 0, 0), "stop_pause");
        game_valid = 1'b1;
        game_secs  = 12'd10;
        applyStimulus(0, 0, 0, 0, mk(24, 0, 0, 1, 0), "off_enter");
        applyStimulus(1, 0, 0, 0, mk(24, 0, 0, 1, 0), "off_start_ignored");
        game_secs = 12'd30;
        applyStimulus(0, 0, 0, 0, mk(24, 0, 0, 1, 0), "off_hold");
        applyStimulus(0, 0, 1, 0, mk(24, 0, 0, 0, 0), "off_exit");
        applyStimulus(0, 0, 0, 0, mk(24, 0, 0, 0, 0), "pause_after_off");
        game_valid = 1'b0;

        // Asynchronous reset mid-buzz.
        applyStimulus(1, 0, 0, 0, mk(24, 1, 0, 0, 0), "start_rst1");
        for (int i = 1; i <= 96; i++)
            applyStimulus(0, 0, 0, 0, mk(24 - i / 4, i < 96, i == 96, 0, i == 96),
                          $sformatf("run_rst1_%0d", i));
        applyStimulus(0, 0, 0, 0, mk(0, 0, 1, 0, 1), "mid_buzz");
        #2 reset_n = 1'b0;
        #1;
        sb.push_back(mk(24, 0, 0, 0, 0));
        checkOutput("async_rst_buzz");
        @(negedge clk);
        reset_n = 1'b1;

        // Asynchronous reset mid-count, then confirm the counter sits in PAUSE.
        applyStimulus(1, 0, 0, 0, mk(24, 1, 0, 0, 0), "start_rst2");
        for (int i = 1; i <= 6; i++)
            applyStimulus(0, 0, 0, 0, mk(24 - i / 4, 1, 0, 0, 0), $sformatf("run_rst2_%0d", i));
        #3 reset_n = 1'b0;
        #1;
        sb.push_back(mk(24, 0, 0, 0, 0));
        checkOutput("async_rst_count");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++)
            applyStimulus(0, 0, 0, 0, mk(24, 0, 0, 0, 0), $sformatf("paused_after_rst_%0d", i));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
